mole_field_ctrl: RTL and testbench

MOLE_FIELD_CTRL -- requirements
Module: mole_field_ctrl

---
 rtl/mole_pkg.sv | 22 ++
 rtl/mole_cell.sv | 97 +++++++++
 rtl/mole_field_ctrl.sv | 106 ++++++++++
 tb/tb_mole_field_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole field: state encoding, difficulty
// scale table and timer sizing.
package mole_pkg;

  // Longest up-time is (7+1)*4 = 32 ticks, which needs 6 bits.
  localparam int unsigned TIMER_W = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UP       = 2'd1,
    COOLDOWN = 2'd2
  } mole_state_e;

  localparam logic [2:0] DIFF_SCALE [4] = '{3'd4, 3'd3, 3'd2, 3'd1};

  // Up-time in ticks for a freshly raised mole.
  function automatic logic [TIMER_W-1:0] up_ticks(input logic [1:0] difficulty,
                                                  input logic [2:0] moletime);
    return (TIMER_W'(moletime) + TIMER_W'(1)) * TIMER_W'(DIFF_SCALE[difficulty]);
  endfunction

endpackage

// File: rtl/mole_cell.sv
// One mole channel: IDLE/UP/COOLDOWN state machine with its tick timer and
// single-cycle hit/miss/wrong event strobes.
import mole_pkg::*;

module mole_cell #(
  parameter int unsigned COOL_TICKS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               tick,
  input  logic               grant,
  input  logic               whack,
  input  logic [TIMER_W-1:0] load_ticks,
  output logic               up,
  output logic               idle_c,
  output logic               up_nxt_c,
  output logic               hit_c,
  output logic               miss_c,
  output logic               wrong_c
);

  localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOL_TICKS);

  mole_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Whack wins over a same-cycle expiry, so a late hit is never scored as a miss.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hit_c   = 1'b0;
    miss_c  = 1'b0;
    wrong_c = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wrong_c = whack;
          if (grant) begin
            state_d = UP;
            timer_d = load_ticks;
          end
        end
        UP: begin
          if (whack) begin
            hit_c   = 1'b1;
            state_d = COOLDOWN;
            timer_d = COOL_LOAD;
          end else if (tick) begin
            if (timer_q <= TIMER_W'(1)) begin
              miss_c  = 1'b1;
              state_d = COOLDOWN;
              timer_d = COOL_LOAD;
            end else begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
        end
        COOLDOWN: begin
          wrong_c = whack;
          if (timer_q == '0) begin
            state_d = IDLE;
          end else if (tick) begin
            if (timer_q == TIMER_W'(1)) begin
              state_d = IDLE;
              timer_d = '0;
            end else begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  assign up       = (state_q == UP);
  assign idle_c   = (state_q == IDLE);
  assign up_nxt_c = (state_d == UP);

endmodule

// File: rtl/mole_field_ctrl.sv
// Whack-a-mole field controller: tick prescaler, ordered spawn grant against
// the MAX_UP limit, per-mole cells and registered event popcounts.
import mole_pkg::*;

module mole_field_ctrl #(
  parameter int unsigned NUM_MOLES   = 8,
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned MAX_UP      = 4,
  parameter int unsigned COOL_TICKS  = 2,
  localparam int unsigned CNT_W      = $clog2(NUM_MOLES + 1)
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           difficulty,
  input  logic [2:0]           moletime,
  input  logic [NUM_MOLES-1:0] spawn,
  input  logic [NUM_MOLES-1:0] whack,
  output logic [NUM_MOLES-1:0] omole,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic [CNT_W-1:0]     wrong_cnt,
  output logic [CNT_W-1:0]     up_cnt
);

  localparam int unsigned PS_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned ACC_W = CNT_W + 1;

  logic [PS_W-1:0]      ps_q;
  logic                 tick_c;
  logic [TIMER_W-1:0]   load_ticks_c;
  logic [NUM_MOLES-1:0] grant_c, idle_c, up_nxt_c, hit_c, miss_c, wrong_c;
  logic [ACC_W-1:0]     acc_c;
  logic [CNT_W-1:0]     hit_sum_c, miss_sum_c, wrong_sum_c, up_sum_c;

  assign tick_c = enable && (ps_q == PS_W'(TICK_CYCLES - 1));

  // Prescaler restarts from zero whenever the game is paused.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)                 ps_q <= '0;
    else if (!enable || tick_c) ps_q <= '0;
    else                       ps_q <= ps_q + PS_W'(1);
  end

  assign load_ticks_c = up_ticks(difficulty, moletime);

  // Lowest index wins the free slots; ungranted spawns are simply dropped.
  always_comb begin
    grant_c = '0;
    acc_c   = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      if (enable && spawn[i] && idle_c[i] &&
          (ACC_W'(up_cnt) + acc_c < ACC_W'(MAX_UP))) begin
        grant_c[i] = 1'b1;
        acc_c      = acc_c + ACC_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_mole
    mole_cell #(.COOL_TICKS(COOL_TICKS)) u_cell (
      .clk        (CLK100MHZ),
      .rst        (reset),
      .enable     (enable),
      .tick       (tick_c),
      .grant      (grant_c[g]),
      .whack      (whack[g]),
      .load_ticks (load_ticks_c),
      .up         (omole[g]),
      .idle_c     (idle_c[g]),
      .up_nxt_c   (up_nxt_c[g]),
      .hit_c      (hit_c[g]),
      .miss_c     (miss_c[g]),
      .wrong_c    (wrong_c[g])
    );
  end

  always_comb begin
    hit_sum_c   = '0;
    miss_sum_c  = '0;
    wrong_sum_c = '0;
    up_sum_c    = '0;
    for (int i = 0; i < NUM_MOLES; i++) begin
      hit_sum_c   = hit_sum_c   + CNT_W'(hit_c[i]);
      miss_sum_c  = miss_sum_c  + CNT_W'(miss_c[i]);
      wrong_sum_c = wrong_sum_c + CNT_W'(wrong_c[i]);
      up_sum_c    = up_sum_c    + CNT_W'(up_nxt_c[i]);
    end
  end

  // up_cnt tracks the registered UP states, so it also feeds the grant limit.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      wrong_cnt <= '0;
      up_cnt    <= '0;
    end else begin
      hit_cnt   <= hit_sum_c;
      miss_cnt  <= miss_sum_c;
      wrong_cnt <= wrong_sum_c;
      up_cnt    <= up_sum_c;
    end
  end

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Directed bench for mole_field_ctrl with NUM_MOLES=8, TICK_CYCLES=4,
// MAX_UP=3, COOL_TICKS=2; expected outputs go through a scoreboard queue.
module tb_mole_field_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] difficulty;
  logic [2:0] moletime;
  logic [7:0] spawn;
  logic [7:0] whack;
  logic [7:0] omole;
  logic [3:0] hit_cnt, miss_cnt, wrong_cnt, up_cnt;

  typedef struct {
    logic [7:0] omole;
    logic [3:0] hit;
    logic [3:0] miss;
    logic [3:0] wrong;
    logic [3:0] up;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mole_field_ctrl #(
    .NUM_MOLES   (8),
    .TICK_CYCLES (4),
    .MAX_UP      (3),
    .COOL_TICKS  (2)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .enable     (enable),
    .difficulty (difficulty),
    .moletime   (moletime),
    .spawn      (spawn),
    .whack      (whack),
    .omole      (omole),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wrong_cnt  (wrong_cnt),
    .up_cnt     (up_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [7:0] om, input logic [3:0] h, input logic [3:0] m,
                          input logic [3:0] w, input logic [3:0] u);
    exp_t e;
    e.omole = om; e.hit = h; e.miss = m; e.wrong = w; e.up = u;
    sb.push_back(e);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (omole === e.omole) else begin
      errors++; $error("FAIL %s omole: observed %h expected %h", tag, omole, e.omole);
    end
    checks++;
    assert (hit_cnt === e.hit) else begin
      errors++; $error("FAIL %s hit_cnt: observed %0d expected %0d", tag, hit_cnt, e.hit);
    end
    checks++;
    assert (miss_cnt === e.miss) else begin
      errors++; $error("FAIL %s miss_cnt: observed %0d expected %0d", tag, miss_cnt, e.miss);
    end
    checks++;
    assert (wrong_cnt === e.wrong) else begin
      errors++; $error("FAIL %s wrong_cnt: observed %0d expected %0d", tag, wrong_cnt, e.wrong);
    end
    checks++;
    assert (up_cnt === e.up) else begin
      errors++; $error("FAIL %s up_cnt: observed %0d expected %0d", tag, up_cnt, e.up);
    end
  endtask

  // One clock: record expectation, clock, drop the one-cycle pulses, compare.
  task automatic cyc(input logic [7:0] om, input logic [3:0] h, input logic [3:0] m,
                     input logic [3:0] w, input logic [3:0] u, input string tag);
    push_exp(om, h, m, w, u);
    @(posedge clk); #1;
    spawn = '0;
    whack = '0;
    check_front(tag);
  endtask

  task automatic run(input int n, input logic [7:0] om, input logic [3:0] u, input string tag);
    for (int i = 0; i < n; i++) cyc(om, 4'd0, 4'd0, 4'd0, u, tag);
  endtask

  task automatic chk_now(input logic [7:0] om, input logic [3:0] u, input string tag);
    push_exp(om, 4'd0, 4'd0, 4'd0, u);
    check_front(tag);
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; spawn = '0; whack = '0;
    difficulty = 2'd0; moletime = 3'd0;
    @(posedge clk); #1;
    chk_now(8'h00, 4'd0, "reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Expiry, cooldown lockout, hit, late hit, wrong whacks on mole 3 / mole 5.
    reset_dut();
    enable = 1'b1; spawn = 8'h08; moletime = 3'd1; difficulty = 2'd3;
    cyc(8'h08, 0, 0, 0, 1, "spawn3");
    moletime = 3'd7; difficulty = 2'd0;
    run(6, 8'h08, 4'd1, "up3_hold");
    cyc(8'h00, 0, 1, 0, 0, "expire3");
    spawn = 8'h08;
    cyc(8'h00, 0, 0, 0, 0, "spawn_in_cool");
    run(7, 8'h00, 4'd0, "cool3");
    spawn = 8'h08; moletime = 3'd0; difficulty = 2'd0;
    cyc(8'h08, 0, 0, 0, 1, "respawn3");
    whack = 8'h08;
    cyc(8'h00, 1, 0, 0, 0, "hit3");
    spawn = 8'h08;
    cyc(8'h00, 0, 0, 0, 0, "spawn_after_hit_a");
    run(1, 8'h00, 4'd0, "cool_after_hit");
    spawn = 8'h08;
    cyc(8'h00, 0, 0, 0, 0, "spawn_after_hit_b");
    run(3, 8'h00, 4'd0, "cool_after_hit");
    spawn = 8'h08; moletime = 3'd0; difficulty = 2'd3;
    cyc(8'h08, 0, 0, 0, 1, "spawn3_short");
    run(2, 8'h08, 4'd1, "up3_short");
    whack = 8'h08;
    cyc(8'h00, 1, 0, 0, 0, "whack_on_final_tick");
    whack = 8'h28;
    cyc(8'h00, 0, 0, 2, 0, "wrong_idle_cool");
    run(1, 8'h00, 4'd0, "quiet");

    // Grant limit, ordered grant, pause, async reset, tick phase after enable.
    reset_dut();
    enable = 1'b1; spawn = 8'hFF; moletime = 3'd7; difficulty = 2'd0;
    cyc(8'h07, 0, 0, 0, 3, "spawn_all");
    spawn = 8'hF8;
    cyc(8'h07, 0, 0, 0, 3, "spawn_when_full");
    whack = 8'h01;
    cyc(8'h06, 1, 0, 0, 2, "hit0");
    spawn = 8'hF1;
    cyc(8'h16, 0, 0, 0, 3, "grant_one_slot");
    whack = 8'h82;
    cyc(8'h14, 1, 0, 1, 2, "hit1_wrong7");
    enable = 1'b0; whack = 8'h04;
    cyc(8'h00, 0, 0, 0, 0, "disable");
    run(2, 8'h00, 4'd0, "disabled");
    enable = 1'b1; spawn = 8'h01; moletime = 3'd0; difficulty = 2'd3;
    cyc(8'h01, 0, 0, 0, 1, "spawn0");
    reset = 1'b1;
    #2;
    chk_now(8'h00, 4'd0, "async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    run(8, 8'h00, 4'd0, "after_reset_no_miss");
    enable = 1'b0;
    cyc(8'h00, 0, 0, 0, 0, "pause");
    enable = 1'b1; spawn = 8'h01;
    cyc(8'h01, 0, 0, 0, 1, "spawn0_phase");
    run(2, 8'h01, 4'd1, "up0_phase");
    cyc(8'h00, 0, 1, 0, 0, "first_tick_expire");
    run(1, 8'h00, 4'd0, "quiet_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
